// File: rtl/reg_bank_reader.sv
// reg_bank_reader: a bank of DEPTH registers with a direct write port and an
// in-order, valid/ready read-back port backed by a two-entry response buffer.
module reg_bank_reader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic [AW-1:0]    rd_addr,
    output logic             rd_rsp_valid,
    input  logic             rd_rsp_ready,
    output logic [WIDTH-1:0] rd_rsp_data,
    output logic [AW-1:0]    rd_rsp_addr,
    output logic             rd_rsp_err
);

    // One extra bit so DEPTH == 2^AW still fits in the limit constant.
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];

    logic [WIDTH-1:0] buf_data [2];
    logic [AW-1:0]    buf_addr [2];
    logic             buf_err  [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    logic             wr_ok;
    logic             rd_ok;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] cap_data;

    assign wr_ok        = ({1'b0, wr_addr} < DEPTH_LIM);
    assign rd_ok        = ({1'b0, rd_addr} < DEPTH_LIM);
    assign rd_req_ready = (count < 2'd2);
    assign rd_rsp_valid = (count != 2'd0);
    assign push         = rd_req_valid & rd_req_ready;
    assign pop          = rd_rsp_valid & rd_rsp_ready;

    assign rd_rsp_data  = buf_data[rd_ptr];
    assign rd_rsp_addr  = buf_addr[rd_ptr];
    assign rd_rsp_err   = buf_err[rd_ptr];

    // Register bank write; an address beyond DEPTH matches no register and is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == AW'(i)) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Capture value for a new request, forwarding a same-cycle write so it is never missed.
    always_comb begin
        cap_data = '0;
        if (rd_ok) begin
            if (wr_en && wr_ok && (wr_addr == rd_addr)) begin
                cap_data = wr_data;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_addr == AW'(i)) begin
                        cap_data = regs[i];
                    end
                end
            end
        end
    end

    // Two-entry response FIFO: entries are snapshots, frozen until popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_addr[i] <= '0;
                buf_err[i]  <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= cap_data;
                buf_addr[wr_ptr] <= rd_addr;
                buf_err[wr_ptr]  <= ~rd_ok;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed self-checking bench for reg_bank_reader (DEPTH = 6 so that the
// out-of-range addresses 6 and 7 are reachable with AW = 3).
module tb_reg_bank_reader;

    localparam int WIDTH = 16;
    localparam int DEPTH = 6;
    localparam int AW    = 3;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_req_valid;
    logic             rd_req_ready;
    logic [AW-1:0]    rd_addr;
    logic             rd_rsp_valid;
    logic             rd_rsp_ready;
    logic [WIDTH-1:0] rd_rsp_data;
    logic [AW-1:0]    rd_rsp_addr;
    logic             rd_rsp_err;

    int check_count;
    int fail_count;

    logic [WIDTH-1:0] model_regs [8];

    reg_bank_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_addr      (rd_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data  (rd_rsp_data),
        .rd_rsp_addr  (rd_rsp_addr),
        .rd_rsp_err   (rd_rsp_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then settle 1 ns past the edge.
    task automatic applyStimulus(input logic w_en, input logic [AW-1:0] w_addr,
                                 input logic [WIDTH-1:0] w_data, input logic r_valid,
                                 input logic [AW-1:0] r_addr, input logic r_ready);
        wr_en        = w_en;
        wr_addr      = w_addr;
        wr_data      = w_data;
        rd_req_valid = r_valid;
        rd_addr      = r_addr;
        rd_rsp_ready = r_ready;
        @(posedge clk);
        if (w_en && (int'(w_addr) < DEPTH)) model_regs[w_addr] = w_data;
        #1;
    endtask

    function automatic logic [WIDTH-1:0] exp_data(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) ? model_regs[a] : '0;
    endfunction

    function automatic logic exp_err(input logic [AW-1:0] a);
        return (int'(a) >= DEPTH);
    endfunction

    initial begin
        check_count = 0;
        fail_count  = 0;
        for (int i = 0; i < 8; i++) model_regs[i] = '0;
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req_valid = 1'b0; rd_addr = '0; rd_rsp_ready = 1'b0;
        #23;
        rst = 1'b0;
        #1;

        // Reset state
        checkOutput("reset_valid", 32'(rd_rsp_valid), 32'd0);
        checkOutput("reset_data",  32'(rd_rsp_data),  32'd0);
        checkOutput("reset_addr",  32'(rd_rsp_addr),  32'd0);
        checkOutput("reset_err",   32'(rd_rsp_err),   32'd0);
        checkOutput("reset_ready", 32'(rd_req_ready), 32'd1);

        // Basic write then read
        applyStimulus(1'b1, 3'd3, 16'hABCD, 1'b0, 3'd0, 1'b1);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1);
        checkOutput("basic_valid", 32'(rd_rsp_valid), 32'd1);
        checkOutput("basic_data",  32'(rd_rsp_data),  32'hABCD);
        checkOutput("basic_addr",  32'(rd_rsp_addr),  32'd3);
        checkOutput("basic_err",   32'(rd_rsp_err),   32'd0);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1);
        checkOutput("basic_popped", 32'(rd_rsp_valid), 32'd0);

        // Same-cycle write bypass, then snapshot holds against a later write
        applyStimulus(1'b1, 3'd5, 16'hFFFF, 1'b1, 3'd5, 1'b0);
        checkOutput("bypass_valid", 32'(rd_rsp_valid), 32'd1);
        checkOutput("bypass_data",  32'(rd_rsp_data),  32'hFFFF);
        applyStimulus(1'b1, 3'd5, 16'hAAAA, 1'b0, 3'd0, 1'b0);
        checkOutput("snap_data",  32'(rd_rsp_data),  32'hFFFF);
        checkOutput("snap_addr",  32'(rd_rsp_addr),  32'd5);
        checkOutput("snap_valid", 32'(rd_rsp_valid), 32'd1);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1);
        checkOutput("snap_popped", 32'(rd_rsp_valid), 32'd0);

        // Backpressure: fill the buffer, stall a third request, drain in order
        applyStimulus(1'b1, 3'd1, 16'h1111, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b0);
        checkOutput("bp_ready_1", 32'(rd_req_ready), 32'd1);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0);
        checkOutput("bp_ready_full", 32'(rd_req_ready), 32'd0);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b0);
        checkOutput("bp_stall_ready", 32'(rd_req_ready), 32'd0);
        checkOutput("bp_head_addr1",  32'(rd_rsp_addr),  32'd1);
        checkOutput("bp_head_data1",  32'(rd_rsp_data),  32'h1111);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b1);
        checkOutput("bp_head_addr2",  32'(rd_rsp_addr),  32'd2);
        checkOutput("bp_head_data2",  32'(rd_rsp_data),  32'h2222);
        checkOutput("bp_ready_back",  32'(rd_req_ready), 32'd1);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b1);
        checkOutput("bp_head_addr4",  32'(rd_rsp_addr),  32'd4);
        checkOutput("bp_head_data4",  32'(rd_rsp_data),  32'h4444);
        checkOutput("bp_valid4",      32'(rd_rsp_valid), 32'd1);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1);
        checkOutput("bp_drained", 32'(rd_rsp_valid), 32'd0);

        // Out-of-range read and ignored out-of-range write
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 1'b0);
        checkOutput("oor_valid", 32'(rd_rsp_valid), 32'd1);
        checkOutput("oor_err",   32'(rd_rsp_err),   32'd1);
        checkOutput("oor_data",  32'(rd_rsp_data),  32'd0);
        checkOutput("oor_addr",  32'(rd_rsp_addr),  32'd7);
        applyStimulus(1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd0, 1'b1);
        for (int a = 0; a < 7; a++) begin
            applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'(a), 1'b1);
            checkOutput($sformatf("oor_rb_data%0d", a), 32'(rd_rsp_data), 32'(exp_data(3'(a))));
            checkOutput($sformatf("oor_rb_err%0d", a),  32'(rd_rsp_err),  32'(exp_err(3'(a))));
        end
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1);

        // Steady stream: one request and one response per cycle
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b1, 3'(a), 16'(16'h1000 + a), 1'b0, 3'd0, 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'(i % 8), 1'b1);
            checkOutput($sformatf("stream_valid%0d", i), 32'(rd_rsp_valid), 32'd1);
            checkOutput($sformatf("stream_ready%0d", i), 32'(rd_req_ready), 32'd1);
            checkOutput($sformatf("stream_addr%0d", i),  32'(rd_rsp_addr),  32'(i % 8));
            checkOutput($sformatf("stream_data%0d", i),  32'(rd_rsp_data),  32'(exp_data(3'(i % 8))));
            checkOutput($sformatf("stream_err%0d", i),   32'(rd_rsp_err),   32'(exp_err(3'(i % 8))));
        end
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1);
        checkOutput("stream_drained", 32'(rd_rsp_valid), 32'd0);

        // Asynchronous reset with two responses buffered
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0);
        checkOutput("prerst_full", 32'(rd_req_ready), 32'd0);
        rd_req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(rd_rsp_valid), 32'd0);
        for (int i = 0; i < 8; i++) model_regs[i] = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("postrst_ready", 32'(rd_req_ready), 32'd1);
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'(a), 1'b1);
            checkOutput($sformatf("postrst_data%0d", a), 32'(rd_rsp_data), 32'd0);
            checkOutput($sformatf("postrst_addr%0d", a), 32'(rd_rsp_addr), 32'(a));
        end
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1);
        checkOutput("postrst_drained", 32'(rd_rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/reg_bank_reader.md
Name: reg_bank_reader

Overview:
- Bank of DEPTH WIDTH-bit registers with one direct write port and a handshaked read-back port.
- Read requests (address) are accepted with valid/ready. Responses (data plus address) are returned in request order through a 2-entry response buffer.
- Sits between the datapath registers and any consumer (debug/readback logic, bus slave) that must read register contents without stalling writers.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers; legal range 2..256.
- AW, 3, address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd_req_valid  in  1  read request present.
- rd_req_ready  out  1  block can accept a request this cycle.
- rd_addr  in  AW  read address; sampled on request acceptance.
- rd_rsp_valid  out  1  response at buffer head is valid.
- rd_rsp_ready  in  1  consumer takes the response this cycle.
- rd_rsp_data  out  WIDTH  response data.
- rd_rsp_addr  out  AW  address the response belongs to.
- rd_rsp_err  out  1  1 when the requested address was >= DEPTH.

Behaviour:
- Reset (async, immediate on rst high):
  - All registers = 0; buffer count = 0.
  - rd_rsp_valid = 0, rd_rsp_data = 0, rd_rsp_addr = 0, rd_rsp_err = 0, rd_req_ready = 1 once rst deasserts.
  - Reset mid-transaction discards all buffered responses; no response is owed after reset.
- Write:
  - On clk, if wr_en and wr_addr < DEPTH, then regs[wr_addr] <= wr_data.
  - wr_addr >= DEPTH: write ignored, no side effect.
  - Writes never stall and are independent of the read handshake.
- Request accept: push = rd_req_valid & rd_req_ready.
- rd_req_ready = (count < 2). Combinational from count only; no dependency on rd_rsp_ready, so a full buffer blocks even if the consumer pops in the same cycle.
- Response capture on push:
  - Entry gets data = regs[rd_addr], addr = rd_addr, err = 0.
  - Write bypass: if wr_en and wr_addr == rd_addr in the same cycle (address < DEPTH), the entry captures wr_data, not the old contents.
  - rd_addr >= DEPTH: data = 0, err = 1.
- Latency: a request accepted at edge N has its response visible at the head (rd_rsp_valid = 1) after edge N when the buffer was empty. Otherwise it appears after the older entry pops.
- Response snapshot: captured data is frozen. A later write to the same register does not change a buffered response.
- Pop: pop = rd_rsp_valid & rd_rsp_ready.
  - The head advances and rd_rsp_* shows the next entry, or rd_rsp_valid = 0 if the buffer is empty.
- Head stability: while rd_rsp_valid & !rd_rsp_ready, rd_rsp_data, rd_rsp_addr and rd_rsp_err hold stable.
- Count update: push only +1; pop only -1; push & pop: unchanged, order preserved (FIFO).
- Buffer: 2 entries, circular wr/rd pointers of 1 bit each, wrapping modulo 2. Count is 2 bits, 0..2, never exceeds 2 and never underflows.
- Outputs are registered except rd_req_ready, which is a decode of the count register. No combinational path from any input to any output.
- rd_rsp_valid = (count != 0).

Test Plan:
- Reset, then write 0xABCD to addr 3; request addr 3 with rd_rsp_ready = 1 -> one cycle later rd_rsp_valid = 1, data 0xABCD, addr 3, err 0.
- Same-cycle wr_en (addr 5, 0xFFFF) and request addr 5 -> response data 0xFFFF (bypass). Next cycle write addr 5 = 0xAAAA while the response is held (rd_rsp_ready = 0) -> data stays 0xFFFF.
- Hold rd_rsp_ready = 0 and issue requests for addr 1, 2, 4 back-to-back:
  - First two accepted; rd_req_ready = 0 thereafter; third stalls.
  - Release rd_rsp_ready -> responses addr 1, 2, 4 return in order.
  - rd_req_ready returns to 1 the cycle after the first pop.
- Request addr 7 with DEPTH = 6 -> rd_rsp_err = 1, data 0. Write to addr 7 -> no register changes (reads of addr 0..5 unchanged).
- Steady stream: request every cycle with rd_rsp_ready = 1 for 16 cycles, cycling addresses 0..7 preloaded with 0x1000+addr -> one response per cycle, correct data, count never exceeds 1.
- Assert rst with 2 responses buffered -> rd_rsp_valid drops to 0 immediately (async), all registers read back 0 after release.
